cam_result_reader: RTL and testbench

//  Downstream readout stage for the CAM array. On a start command it sweeps

---
 rtl/cam_result_reader.sv | 206 ++++++++++++++++++++
 tb/tb_cam_result_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_result_reader.sv
// CAM readout stage: sweeps row/column addresses over a wrapping window, captures
// array data at the fixed 2-cycle read latency and streams it through a 4-entry skid FIFO.
module cam_result_reader #(
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned DATA_DEPTH     = 4,
  parameter int unsigned ADDR_WIDTH_CAM = 8,
  parameter int unsigned CNT_WIDTH      = 8,
  parameter logic [2:0]  RowxRow        = 3'd1,
  parameter logic [2:0]  ColxCol        = 3'd2,
  localparam int unsigned OUT_W = (DATA_WIDTH > DATA_DEPTH) ? DATA_WIDTH : DATA_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      dir,
  input  logic [ADDR_WIDTH_CAM-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]      count,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                input_mode_o,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Col,
  input  logic [DATA_WIDTH-1:0]     Q_out_row,
  input  logic [DATA_DEPTH-1:0]     Q_out_col,
  output logic [OUT_W-1:0]          m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned OCC_W      = 3;
  localparam int unsigned PTR_W      = 2;
  localparam logic [ADDR_WIDTH_CAM-1:0] PARK_ROW = ADDR_WIDTH_CAM'(DATA_DEPTH + 3);
  localparam logic [ADDR_WIDTH_CAM-1:0] PARK_COL = ADDR_WIDTH_CAM'(DATA_WIDTH + 3);
  localparam logic [ADDR_WIDTH_CAM-1:0] LEN_ROW  = ADDR_WIDTH_CAM'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH_CAM-1:0] LEN_COL  = ADDR_WIDTH_CAM'(DATA_WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]                r_state;
  logic                      r_dir;
  logic [CNT_WIDTH-1:0]      r_count;
  logic [CNT_WIDTH-1:0]      r_issued;
  logic [ADDR_WIDTH_CAM-1:0] r_idx;
  logic [ADDR_WIDTH_CAM-1:0] r_addr_row;
  logic [ADDR_WIDTH_CAM-1:0] r_addr_col;
  logic [2:0]                r_mode;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_s1;
  logic                      r_s1_last;
  logic                      r_s2;
  logic                      r_s2_last;
  logic [OUT_W-1:0]          r_fifo_dat [FIFO_DEPTH];
  logic                      r_fifo_lst [FIFO_DEPTH];
  logic [OCC_W-1:0]          r_occ;
  logic                      r_m_valid;

  logic [1:0]                w_state_nxt;
  logic                      w_start_ok;
  logic                      w_issue;
  logic                      w_pop;
  logic                      w_credit;
  logic                      w_last_issue;
  logic                      w_drain_done;
  logic                      w_dir_eff;
  logic [OCC_W:0]            w_outstanding;
  logic [ADDR_WIDTH_CAM-1:0] w_len;
  logic [ADDR_WIDTH_CAM-1:0] w_idx_inc;
  logic [ADDR_WIDTH_CAM-1:0] w_base_mod;
  logic [OUT_W-1:0]          w_push_dat;
  logic [PTR_W-1:0]          w_wr_idx;
  logic [OUT_W-1:0]          w_fifo_dat_nxt [FIFO_DEPTH];
  logic                      w_fifo_lst_nxt [FIFO_DEPTH];
  logic [OCC_W-1:0]          w_occ_nxt;

  // Credit counts words still in the read pipe so the FIFO can never overflow.
  assign w_pop         = r_m_valid & m_ready;
  assign w_outstanding = (OCC_W+1)'(r_occ) + (OCC_W+1)'(r_s1) + (OCC_W+1)'(r_s2);
  assign w_credit      = w_outstanding < (OCC_W+1)'(FIFO_DEPTH);
  assign w_last_issue  = (r_issued == r_count - CNT_WIDTH'(1));
  assign w_drain_done  = !r_s1 && !r_s2 && (r_occ == OCC_W'(1)) && w_pop;
  assign w_dir_eff     = w_start_ok ? dir : r_dir;
  assign w_len         = r_dir ? LEN_COL : LEN_ROW;
  assign w_idx_inc     = (r_idx == w_len - ADDR_WIDTH_CAM'(1)) ? '0 : r_idx + ADDR_WIDTH_CAM'(1);
  assign w_base_mod    = dir ? (base_addr % LEN_COL) : (base_addr % LEN_ROW);
  assign w_push_dat    = r_dir ? OUT_W'(Q_out_col) : OUT_W'(Q_out_row);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = (count == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (w_last_issue) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (w_drain_done) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift-register FIFO: head always at entry 0, entries at or above occupancy stay zero.
  always_comb begin
    w_fifo_dat_nxt = r_fifo_dat;
    w_fifo_lst_nxt = r_fifo_lst;
    if (w_pop) begin
      for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) begin
        w_fifo_dat_nxt[i] = r_fifo_dat[i+1];
        w_fifo_lst_nxt[i] = r_fifo_lst[i+1];
      end
      w_fifo_dat_nxt[FIFO_DEPTH-1] = '0;
      w_fifo_lst_nxt[FIFO_DEPTH-1] = 1'b0;
    end
    w_wr_idx = PTR_W'(w_pop ? r_occ - OCC_W'(1) : r_occ);
    if (r_s2) begin
      w_fifo_dat_nxt[w_wr_idx] = w_push_dat;
      w_fifo_lst_nxt[w_wr_idx] = r_s2_last;
    end
    w_occ_nxt = r_occ + OCC_W'(r_s2) - OCC_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dir      <= 1'b0;
      r_count    <= '0;
      r_issued   <= '0;
      r_idx      <= '0;
      r_addr_row <= PARK_ROW;
      r_addr_col <= PARK_COL;
      r_mode     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_s1       <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2       <= 1'b0;
      r_s2_last  <= 1'b0;
      r_occ      <= '0;
      r_m_valid  <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_dat[i] <= '0;
        r_fifo_lst[i] <= 1'b0;
      end
    end else begin
      assert (!(r_s2 && r_occ == OCC_W'(FIFO_DEPTH)))
        else $error("cam_result_reader: push into full fifo");
      if (w_start_ok) begin
        r_dir    <= dir;
        r_count  <= count;
        r_issued <= '0;
        r_idx    <= w_base_mod;
      end else if (w_issue) begin
        r_idx    <= w_idx_inc;
        r_issued <= r_issued + CNT_WIDTH'(1);
      end
      // Address holds through credit bubbles and parks once issuing ends.
      if (w_issue) begin
        if (r_dir) r_addr_col <= r_idx;
        else       r_addr_row <= r_idx;
      end else if (w_state_nxt != S_ISSUE) begin
        r_addr_row <= PARK_ROW;
        r_addr_col <= PARK_COL;
      end
      r_mode     <= (w_state_nxt == S_ISSUE || w_state_nxt == S_DRAIN) ?
                    (w_dir_eff ? ColxCol : RowxRow) : 3'd0;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (r_state == S_FIN);
      r_s1       <= w_issue;
      r_s1_last  <= w_issue & w_last_issue;
      r_s2       <= r_s1;
      r_s2_last  <= r_s1_last;
      r_fifo_dat <= w_fifo_dat_nxt;
      r_fifo_lst <= w_fifo_lst_nxt;
      r_occ      <= w_occ_nxt;
      r_m_valid  <= (w_occ_nxt != '0);
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign input_mode_o    = r_mode;
  assign addr_output_Row = r_addr_row;
  assign addr_output_Col = r_addr_col;
  assign m_data          = r_fifo_dat[0];
  assign m_last          = r_fifo_lst[0];
  assign m_valid         = r_m_valid;

endmodule

// File: tb/tb_cam_result_reader.sv
// Bench for cam_result_reader: a 2-cycle-latency CAM array model plus a word-list
// scoreboard derived from the sweep rules, checked every cycle, and directed literal checks.
module tb_cam_result_reader;

  localparam logic [7:0] PARK = 8'd7;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dir;
  logic [7:0] base_addr;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [2:0] input_mode_o;
  logic [7:0] addr_output_Row;
  logic [7:0] addr_output_Col;
  logic [3:0] Q_out_row;
  logic [3:0] Q_out_col;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  cam_result_reader dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .input_mode_o(input_mode_o),
    .addr_output_Row(addr_output_Row), .addr_output_Col(addr_output_Col),
    .Q_out_row(Q_out_row), .Q_out_col(Q_out_col), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: address registered once, data read combinationally -> sampled 2 edges later.
  logic [3:0] mem [4];
  logic [7:0] a1_row;
  logic [7:0] a1_col;
  always @(posedge clk) begin
    a1_row <= addr_output_Row;
    a1_col <= addr_output_Col;
  end
  always_comb begin
    Q_out_row = (a1_row < 8'd4) ? mem[a1_row[1:0]] : 4'd0;
    Q_out_col = 4'd0;
    if (a1_col < 8'd4)
      for (int r = 0; r < 4; r++) Q_out_col[r] = mem[r][a1_col[1:0]];
  end

  int         total;
  int         bad;
  logic [3:0] exp_dat [64];
  logic       exp_lst [64];
  int         exp_wr;
  int         exp_rd;
  int         done_due;
  int         done_cnt;
  logic       stall_prev;
  logic [3:0] prev_d;
  logic       prev_l;
  logic       cur_dir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] line_word(input logic d, input int idx);
    logic [3:0] w;
    w = 4'd0;
    if (!d) w = mem[idx];
    else for (int r = 0; r < 4; r++) w[r] = mem[r][idx];
    return w;
  endfunction

  // Per-cycle comparison against the scoreboard; sampled at negedge.
  task automatic compare_step();
    if (!rst) begin
      exp_rd     = exp_wr;
      done_due   = 0;
      stall_prev = 1'b0;
      return;
    end
    check("done", 32'(done), 32'(done_due == 1));
    if (done_due > 0) done_due--;
    if (done) done_cnt++;
    if (input_mode_o == 3'd0) begin
      check("row_park", 32'(addr_output_Row), 32'(PARK));
      check("col_park", 32'(addr_output_Col), 32'(PARK));
    end else begin
      check("mode", 32'(input_mode_o), cur_dir ? 32'd2 : 32'd1);
      if (cur_dir) begin
        check("row_park_col", 32'(addr_output_Row), 32'(PARK));
        check("col_range", 32'(addr_output_Col < 8'd4 || addr_output_Col == PARK), 32'd1);
      end else begin
        check("col_park_row", 32'(addr_output_Col), 32'(PARK));
        check("row_range", 32'(addr_output_Row < 8'd4 || addr_output_Row == PARK), 32'd1);
      end
    end
    if (stall_prev) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(prev_d));
      check("hold_last", 32'(m_last), 32'(prev_l));
    end
    if (m_valid) begin
      check("word_expected", 32'(exp_rd != exp_wr), 32'd1);
      if (exp_rd != exp_wr) begin
        check("data", 32'(m_data), 32'(exp_dat[exp_rd]));
        check("last", 32'(m_last), 32'(exp_lst[exp_rd]));
        if (m_ready) begin
          if (exp_lst[exp_rd]) done_due = 2;
          exp_rd++;
        end
      end
    end
    stall_prev = m_valid && !m_ready;
    prev_d     = m_data;
    prev_l     = m_last;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic d, input int base, input int cnt);
    int len;
    start     = 1'b1;
    dir       = d;
    base_addr = 8'(base);
    count     = 8'(cnt);
    cur_dir   = d;
    len       = 4;
    if (cnt == 0) done_due = 3;
    for (int k = 0; k < cnt; k++) begin
      exp_dat[exp_wr] = line_word(d, (base + k) % len);
      exp_lst[exp_wr] = (k == cnt - 1);
      exp_wr++;
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c0;
    int n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < budget) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done_cnt != c0), 32'd1);
  endtask

  task automatic load_mem(input logic [3:0] r0, input logic [3:0] r1,
                          input logic [3:0] r2, input logic [3:0] r3);
    mem[0] = r0; mem[1] = r1; mem[2] = r2; mem[3] = r3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100us");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; exp_wr = 0; exp_rd = 0; done_due = 0; done_cnt = 0;
    stall_prev = 1'b0; prev_d = 4'd0; prev_l = 1'b0; cur_dir = 1'b0;
    rst = 1'b0; start = 1'b0; dir = 1'b0; base_addr = 8'd0; count = 8'd0; m_ready = 1'b1;
    load_mem(4'hA, 4'hB, 4'hC, 4'hD);
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_mode", 32'(input_mode_o), 32'd0);
    check("rst_row", 32'(addr_output_Row), 32'd7);
    check("rst_col", 32'(addr_output_Col), 32'd7);
    rst = 1'b1;
    tick();

    // T1: row sweep with wrap
    launch(1'b0, 1, 4);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_mode", 32'(input_mode_o), 32'd1);
    tick(); tick();
    check("t1_valid_early", 32'(m_valid), 32'd0);
    tick();
    check("t1_valid_lat3", 32'(m_valid), 32'd1);
    check("t1_first_word", 32'(m_data), 32'hB);
    wait_done(20);
    check("t1_all_words", 32'(exp_rd), 32'(exp_wr));
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_done_pulse", 32'(done), 32'd0);

    // T2: column sweep, column 2 = 0110, column 3 = 1100
    load_mem(4'h3, 4'h4, 4'hC, 4'h9);
    launch(1'b1, 2, 2);
    check("t2_mode", 32'(input_mode_o), 32'd2);
    check("t2_busy", 32'(busy), 32'd1);
    tick(); tick(); tick();
    check("t2_word0", 32'(m_data), 32'h6);
    check("t2_busy_mid", 32'(busy), 32'd1);
    wait_done(20);
    check("t2_all_words", 32'(exp_rd), 32'(exp_wr));

    // T3: consumer stalls, issue stops at 4 outstanding
    load_mem(4'hA, 4'hB, 4'hC, 4'hD);
    m_ready = 1'b0;
    launch(1'b0, 0, 8);
    repeat (10) tick();
    check("t3_addr_held", 32'(addr_output_Row), 32'd3);
    check("t3_head", 32'(m_data), 32'hA);
    check("t3_valid", 32'(m_valid), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    m_ready = 1'b1;
    wait_done(40);
    check("t3_all_words", 32'(exp_rd), 32'(exp_wr));

    // T4: zero-length sweep
    launch(1'b0, 2, 0);
    check("t4_valid", 32'(m_valid), 32'd0);
    check("t4_mode", 32'(input_mode_o), 32'd0);
    tick();
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    tick();
    check("t4_done_end", 32'(done), 32'd0);
    check("t4_row_park", 32'(addr_output_Row), 32'd7);

    // T5: start while busy is ignored
    launch(1'b0, 1, 4);
    tick();
    start = 1'b1; dir = 1'b1; base_addr = 8'd0; count = 8'd2;
    tick();
    start = 1'b0;
    check("t5_mode_kept", 32'(input_mode_o), 32'd1);
    wait_done(20);
    repeat (4) tick();
    check("t5_all_words", 32'(exp_rd), 32'(exp_wr));

    // T6: reset mid-sweep with three words buffered
    m_ready = 1'b0;
    launch(1'b0, 0, 8);
    repeat (5) tick();
    check("t6_valid_before", 32'(m_valid), 32'd1);
    rst = 1'b0;
    tick();
    check("t6_valid", 32'(m_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_row", 32'(addr_output_Row), 32'd7);
    check("t6_mode", 32'(input_mode_o), 32'd0);
    check("t6_data", 32'(m_data), 32'd0);
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (6) tick();
    check("t6_no_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
